mips_div_iter: RTL

- Parametrised iterative signed/unsigned integer divider for the OpenMIPS EX stage; next generation of the single-radix divider.
- Produces a remainder/quotient pair in HI/LO layout.
- Adds: operand capture at accept, configurable quotient bits per cycle, ready/valid handshake, divide-by-zero flag, and a defined overflow result.

---
 rtl/mips_div_iter_pkg.sv | 29 ++
 rtl/mips_div_iter_step.sv | 30 +++
 rtl/mips_div_iter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mips_div_iter_pkg.sv
// mips_div_pkg: shared definitions for the iterative MIPS divider.
//   - div_state_e : divider FSM encodings (IDLE/BUSY/FIX/DONE)
//   - calc_iter() : number of BUSY cycles for a given width and radix
//   - twos_mag()  : conditional two's-complement negation (magnitude helper)
// Helpers work on MAX_W-bit values; callers cast to their own width.
package mips_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam int MAX_W = 64;

  // One BUSY cycle retires step quotient bits.
  function automatic int calc_iter(input int width, input int step);
    return width / step;
  endfunction

  // Returns -value when neg is set, value otherwise. Used both for taking
  // operand magnitudes and for restoring result signs.
  function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] value,
                                                input logic neg);
    return neg ? (~value + MAX_W'(1)) : value;
  endfunction

endpackage

// File: rtl/mips_div_iter_step.sv
// mips_div_step: one combinational restoring-division step.
// Ports:
//   rem_i     in  W  partial remainder before the step
//   bit_i     in  1  next dividend bit shifted into the remainder
//   divisor_i in  W  divisor magnitude
//   rem_o     out W  partial remainder after the step
//   qbit_o    out 1  quotient bit produced by this step
module mips_div_step
  import mips_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  qbit_o
);

  logic [DATA_WIDTH:0] trial;

  // rem_i is always below the divisor, so W+1 bits hold the shifted
  // remainder and the sign of the trial difference is exact.
  always_comb begin
    trial  = {rem_i, bit_i} - {1'b0, divisor_i};
    qbit_o = ~trial[DATA_WIDTH];
    rem_o  = qbit_o ? trial[DATA_WIDTH-1:0] : {rem_i[DATA_WIDTH-2:0], bit_i};
  end

endmodule

// File: rtl/mips_div_iter.sv
// mips_div_iter: iterative signed/unsigned divider for the OpenMIPS EX stage.
// Operands are captured at accept; STEP_BITS quotient bits are retired per
// cycle by a chain of mips_div_step instances. Result layout is HI/LO:
// {remainder, quotient}. Quotient truncates toward zero, remainder takes the
// dividend's sign.
// Optional macro MIPS_DIV_FAST_EN: when |op1| < |op2| the result
// {op1, 0} is produced directly without iterating.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   signed_div_i   1 = two's-complement divide, 0 = unsigned
//   opdata1_i      dividend (sampled at accept)
//   opdata2_i      divisor (sampled at accept)
//   start_i        request, accepted when start_i && ready_o && !annul_i
//   annul_i        abort an in-flight divide
//   ready_o        idle, can accept
//   result_o       {remainder, quotient}, held until the next accept
//   valid_o        single-cycle result strobe
//   dbz_o          divide-by-zero flag, qualified by valid_o
module mips_div_iter
  import mips_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP_BITS  = 1,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    signed_div_i,
  input  logic [DATA_WIDTH-1:0]   opdata1_i,
  input  logic [DATA_WIDTH-1:0]   opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic                    ready_o,
  output logic [2*DATA_WIDTH-1:0] result_o,
  output logic                    valid_o,
  output logic                    dbz_o
);

  localparam int ITER = calc_iter(DATA_WIDTH, STEP_BITS);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ITER - 1);

  div_state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]       rem_q, rem_d;
  logic [DATA_WIDTH-1:0]       quo_q, quo_d;
  logic [DATA_WIDTH-1:0]       div_q, div_d;
  logic                        sign1_q, sign1_d;
  logic                        sign2_q, sign2_d;
  logic [2*DATA_WIDTH-1:0]     result_q, result_d;
  logic                        dbz_q, dbz_d;

  logic                        accept;
  logic [DATA_WIDTH-1:0]       op1Mag, op2Mag;
  logic [DATA_WIDTH-1:0]       remFix, quoFix;
  logic [DATA_WIDTH-1:0]       remChain [STEP_BITS+1];
  logic [DATA_WIDTH-1:0]       shChain  [STEP_BITS+1];
  logic [STEP_BITS-1:0]        qbitChain;

  assign accept = start_i && (state_q == ST_IDLE) && !annul_i;

  assign op1Mag = DATA_WIDTH'(twos_mag(MAX_W'(opdata1_i),
                                       signed_div_i & opdata1_i[DATA_WIDTH-1]));
  assign op2Mag = DATA_WIDTH'(twos_mag(MAX_W'(opdata2_i),
                                       signed_div_i & opdata2_i[DATA_WIDTH-1]));

  // Sign flags are only ever set in signed mode, so unsigned results pass
  // through FIX untouched.
  assign remFix = DATA_WIDTH'(twos_mag(MAX_W'(rem_q), sign1_q));
  assign quoFix = DATA_WIDTH'(twos_mag(MAX_W'(quo_q), sign1_q ^ sign2_q));

  // quo_q is a shared shift register: dividend bits leave at the top while
  // quotient bits enter at the bottom, so after ITER cycles it holds |q|.
  assign remChain[0] = rem_q;
  assign shChain[0]  = quo_q;

  for (genvar k = 0; k < STEP_BITS; k++) begin : g_step
    mips_div_step #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
      .rem_i    (remChain[k]),
      .bit_i    (shChain[k][DATA_WIDTH-1]),
      .divisor_i(div_q),
      .rem_o    (remChain[k+1]),
      .qbit_o   (qbitChain[k])
    );
    assign shChain[k+1] = {shChain[k][DATA_WIDTH-2:0], qbitChain[k]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ready_o  = 1'b0;
    valid_o  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (accept) begin
          sign1_d = signed_div_i & opdata1_i[DATA_WIDTH-1];
          sign2_d = signed_div_i & opdata2_i[DATA_WIDTH-1];
          if (opdata2_i == '0) begin
            result_d = '0;
            dbz_d    = 1'b1;
            state_d  = ST_DONE;
          end
`ifdef MIPS_DIV_FAST_EN
          // Quotient is zero and the dividend is already the signed remainder.
          else if (op1Mag < op2Mag) begin
            result_d = {opdata1_i, {DATA_WIDTH{1'b0}}};
            dbz_d    = 1'b0;
            state_d  = ST_DONE;
          end
`endif
          else begin
            rem_d   = '0;
            quo_d   = op1Mag;
            div_d   = op2Mag;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = remChain[STEP_BITS];
          quo_d = shChain[STEP_BITS];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          result_d = {remFix, quoFix};
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign result_o = result_q;
  assign dbz_o    = dbz_q;

endmodule
